// File: rtl/scan_mux_pkg.sv
// Shared types for the registered scan multiplexer: FSM encoding and mode values.
package scan_mux_pkg;

    typedef enum logic [1:0] {MANUAL, SCAN, PAUSED} state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_reg_if.sv
// Channel bank in, selected word and status out; master drives inputs, slave is the mux.
// Latency: n/a (wiring only). Backpressure: none, every signal is sampled each cycle.
interface scan_mux_reg_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SW = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] data_in;
    logic                      mode;
    logic [SW-1:0]             sel;
    logic                      hold;
    logic [WIDTH-1:0]          m;
    logic [SW-1:0]             cur_sel;
    logic                      changed;
    logic                      sel_err;

    modport master (
        output data_in, mode, sel, hold,
        input  m, cur_sel, changed, sel_err
    );

    modport slave (
        input  data_in, mode, sel, hold,
        output m, cur_sel, changed, sel_err
    );

endinterface

// File: rtl/scan_mux_reg_dwell_counter.sv
// Dwell counter 0..DWELL-1; tc flags the last cycle on a channel.
// Latency: tc is combinational from the count. Backpressure: en freezes, clr restarts.
module dwell_counter #(
    parameter int DWELL = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] count;

    assign tc = (count == CW'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_mux_reg.sv
// Registered CHANNELS:1 word mux with manual select or round-robin auto-scan.
// Latency: 1 cycle data_in/sel -> m. Backpressure: none; hold pauses the scan only.
module scan_mux_reg
    import scan_mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 8
) (
    input  logic         clk,
    input  logic         reset,
    scan_mux_reg_if.slave bus
);
    localparam int SW = $clog2(CHANNELS);

    state_t           state, state_nxt;
    logic [SW-1:0]    cur_sel, sel_nxt, sel_wrap;
    logic [WIDTH-1:0] m_q, word_nxt;
    logic             changed_q, sel_err_q, err_nxt;
    logic             cnt_clr, cnt_en, tc;
    logic             sel_ok;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tc)
    );

    // Explicit wrap so non power-of-2 channel counts return to 0.
    assign sel_wrap = (cur_sel == SW'(CHANNELS - 1)) ? '0 : cur_sel + 1'b1;
    assign sel_ok   = ({1'b0, bus.sel} < (SW + 1)'(CHANNELS));

    // A mode change always wins over a dwell expiry on the same edge.
    always_comb begin
        state_nxt = state;
        sel_nxt   = cur_sel;
        err_nxt   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        if (bus.mode == MODE_MANUAL) begin
            state_nxt = MANUAL;
            cnt_clr   = 1'b1;
            if (sel_ok) begin
                sel_nxt = bus.sel;
            end else begin
                err_nxt = 1'b1;
            end
        end else begin
            case (state)
                MANUAL: begin
                    state_nxt = SCAN;
                    cnt_clr   = 1'b1;
                end
                SCAN: begin
                    if (bus.hold) begin
                        state_nxt = PAUSED;
                    end else begin
                        cnt_en = 1'b1;
                        if (tc) sel_nxt = sel_wrap;
                    end
                end
                PAUSED: begin
                    if (!bus.hold) begin
                        state_nxt = SCAN;
                        cnt_en    = 1'b1;
                        if (tc) sel_nxt = sel_wrap;
                    end
                end
                default: state_nxt = MANUAL;
            endcase
        end
    end

    always_comb begin
        word_nxt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_nxt == SW'(k)) word_nxt = bus.data_in[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MANUAL;
            cur_sel   <= '0;
            m_q       <= '0;
            changed_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_sel   <= sel_nxt;
            m_q       <= word_nxt;
            changed_q <= (sel_nxt != cur_sel);
            sel_err_q <= err_nxt;
        end
    end

    assign bus.m       = m_q;
    assign bus.cur_sel = cur_sel;
    assign bus.changed = changed_q;
    assign bus.sel_err = sel_err_q;

endmodule
